// File: rtl/sram_frame_recorder.sv
// SRAM record/playback controller: one fixed 5-cycle SRAM access per qualified pixel strobe,
// with frame-aligned start, single or looped playback and record-length capture.
module sram_frame_recorder #(
    parameter int          ADDR_W    = 18,
    parameter int          DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 2**ADDR_W
) (
    input  logic              clk_x5,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              frame_start,
    input  logic              pix_stb,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_out_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_cs_n,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   rec_len
);

    localparam logic [ADDR_W:0] FRAME_LEN_C = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_REC  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;
    localparam logic [1:0] MODE_LOOP = 2'b11;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        run_mode;
    logic              acc_on;
    logic [2:0]        phase;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   limit;
    logic              is_write, mode_abort, acc_busy, acc_last;
    logic              arm_go, empty_play, reached, end_run, loop_back, start_acc;
    logic              done_d;

    // Phase 4 (A4) is not busy, so a strobe there starts the next access back-to-back.
    assign is_write   = (run_mode == MODE_REC);
    assign mode_abort = (mode == MODE_IDLE);
    assign acc_busy   = acc_on && (phase != 3'd4);
    assign acc_last   = acc_on && (phase == 3'd4);
    assign limit      = is_write ? FRAME_LEN_C : rec_len;
    assign arm_go     = (state_q == ARM) && !mode_abort && frame_start;
    assign empty_play = !is_write && (rec_len == '0);
    assign reached    = acc_last && (word_cnt == limit);
    assign end_run    = (state_q == RUN) &&
                        ((acc_last && (reached || mode_abort)) || (!acc_on && mode_abort));
    assign loop_back  = reached && (run_mode == MODE_LOOP) && !mode_abort;
    assign start_acc  = pix_stb && pix_valid && !acc_busy && !mode_abort &&
                        (((state_q == RUN) && !end_run) || (arm_go && !empty_play));

    always_ff @(posedge clk_x5 or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!mode_abort) state_d = ARM;
            ARM: begin
                if (mode_abort)
                    state_d = IDLE;
                else if (frame_start)
                    state_d = empty_play ? ((run_mode == MODE_LOOP) ? ARM : IDLE) : RUN;
            end
            RUN: if (end_run) state_d = loop_back ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ARM) || (state_q == RUN);
        done_d = 1'b0;
        if (arm_go && empty_play && (run_mode == MODE_ONCE))
            done_d = 1'b1;
        if (end_run && (is_write || ((run_mode == MODE_ONCE) && reached)))
            done_d = 1'b1;
    end

    // Access sequencer and datapath; reset abandons any access with all strobes deasserted.
    always_ff @(posedge clk_x5 or negedge reset) begin
        if (!reset) begin
            run_mode      <= MODE_IDLE;
            acc_on        <= 1'b0;
            phase         <= 3'd0;
            word_cnt      <= '0;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            sram_dq_oe    <= 1'b0;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_cs_n     <= 1'b1;
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            rec_len       <= FRAME_LEN_C;
        end else begin
            pix_out_valid <= 1'b0;
            done          <= done_d;
            if (pix_stb && acc_busy)
                overflow <= 1'b1;
            if ((state_q == IDLE) && !mode_abort)
                run_mode <= mode;
            if (arm_go || loop_back) begin
                sram_addr <= '0;
                word_cnt  <= '0;
            end
            if (end_run && is_write)
                rec_len <= word_cnt;

            if (start_acc) begin
                acc_on    <= 1'b1;
                phase     <= 3'd0;
                sram_cs_n <= 1'b0;
                if (is_write) begin
                    sram_dq_o  <= pix_in;
                    sram_dq_oe <= 1'b1;
                end else begin
                    sram_oe_n  <= 1'b0;
                end
            end else if (acc_on) begin
                case (phase)
                    3'd0: begin
                        phase <= 3'd1;
                        if (is_write) sram_we_n <= 1'b0;
                    end
                    3'd1: phase <= 3'd2;
                    3'd2: begin
                        phase <= 3'd3;
                        if (is_write) begin
                            sram_we_n <= 1'b1;
                        end else begin
                            pix_out       <= sram_dq_i;
                            pix_out_valid <= 1'b1;
                        end
                    end
                    3'd3: begin
                        phase      <= 3'd4;
                        sram_dq_oe <= 1'b0;
                        sram_oe_n  <= 1'b1;
                        sram_cs_n  <= 1'b1;
                        if (!loop_back) sram_addr <= sram_addr + ADDR_W'(1);
                        word_cnt   <= word_cnt + (ADDR_W+1)'(1);
                    end
                    default: acc_on <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_frame_recorder.sv
// Directed bench for sram_frame_recorder with a small behavioural SRAM; FRAME_LEN=8 on a 4-bit address.
module tb_sram_frame_recorder;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk_x5 = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic              frame_start, pix_stb, pix_valid;
    logic [DATA_W-1:0] pix_in, pix_out;
    logic              pix_out_valid;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o, sram_dq_i;
    logic              sram_dq_oe, sram_we_n, sram_oe_n, sram_cs_n;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   rec_len;

    logic [DATA_W-1:0] mem [16];
    int                n_checks = 0;
    int                n_fail = 0;
    int                bus_viol = 0;
    logic [DATA_W-1:0] got;
    int                lat;

    sram_frame_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(8)) dut (
        .clk_x5(clk_x5), .reset(reset), .mode(mode), .frame_start(frame_start),
        .pix_stb(pix_stb), .pix_valid(pix_valid), .pix_in(pix_in), .pix_out(pix_out),
        .pix_out_valid(pix_out_valid), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_cs_n(sram_cs_n), .busy(busy), .done(done),
        .overflow(overflow), .rec_len(rec_len)
    );

    always #4 clk_x5 = ~clk_x5;

    always @(posedge clk_x5)
        if (!sram_cs_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;

    assign sram_dq_i = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

    always @(negedge clk_x5)
        if (reset === 1'b1) begin
            if (sram_dq_oe && !sram_oe_n) bus_viol++;
            if (!sram_we_n && !sram_dq_oe) bus_viol++;
        end

    task automatic step();
        @(posedge clk_x5);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One strobe then A0..A4; returns the last pix_out_valid value and its cycle offset.
    task automatic apply_stimulus(input logic [7:0] pix, input logic fs,
                                  output logic [7:0] pix_got, output int pix_lat);
        pix_in = pix; pix_stb = 1'b1; pix_valid = 1'b1; frame_start = fs;
        pix_got = 8'h00; pix_lat = -1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin pix_stb = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; end
            if (pix_out_valid === 1'b1) begin pix_got = pix_out; pix_lat = k; end
        end
    endtask

    initial begin
        reset = 1'b0; mode = 2'b00; frame_start = 1'b0; pix_stb = 1'b0; pix_valid = 1'b0; pix_in = '0;
        step(); step();
        check_output("rst_we_n", sram_we_n, 1);
        check_output("rst_oe_n", sram_oe_n, 1);
        check_output("rst_cs_n", sram_cs_n, 1);
        check_output("rst_dq_oe", sram_dq_oe, 0);
        check_output("rst_addr", sram_addr, 0);
        check_output("rst_dq_o", sram_dq_o, 0);
        check_output("rst_pix_out", pix_out, 0);
        check_output("rst_flags", {pix_out_valid, done, overflow, busy}, 0);
        check_output("rst_rec_len", rec_len, 8);
        reset = 1'b1; step();

        // Write cycle timing for a frame_start-aligned first pixel
        mode = 2'b01; step();
        check_output("arm_busy", busy, 1);
        pix_in = 8'hA5; frame_start = 1'b1; pix_stb = 1'b1; pix_valid = 1'b1; step();
        frame_start = 1'b0; pix_stb = 1'b0; pix_valid = 1'b0;
        check_output("a0_ctl", {sram_cs_n, sram_dq_oe, sram_we_n, sram_oe_n}, 4'b0111);
        check_output("a0_dq_o", sram_dq_o, 8'hA5);
        step(); check_output("a1_we_oe", {sram_we_n, sram_dq_oe}, 2'b01);
        step(); check_output("a2_we_oe", {sram_we_n, sram_dq_oe}, 2'b01);
        step(); check_output("a3_ctl", {sram_we_n, sram_dq_oe, sram_addr}, {2'b11, 4'd0});
        step(); check_output("a4_ctl", {sram_cs_n, sram_dq_oe, sram_addr}, {2'b10, 4'd1});
        mode = 2'b00; step();
        check_output("abort1_done", done, 1);
        check_output("abort1_rec_len", rec_len, 1);
        check_output("abort1_busy", busy, 0);
        step(); check_output("done_pulse_1cyc", done, 0);

        // Full 8-word record
        mode = 2'b01; step();
        for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h10 + i), i == 0, got, lat);
        step();
        check_output("rec_done", done, 1);
        check_output("rec_len_full", rec_len, 8);
        check_output("rec_addr_end", sram_addr, 8);
        check_output("rec_busy", busy, 0);
        mode = 2'b00; step();

        // Play once: every word returns 4 cycles after its strobe
        mode = 2'b10; step();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(8'h00, i == 0, got, lat);
            check_output($sformatf("play_pix%0d", i), got, 32'h10 + i);
            check_output($sformatf("play_lat%0d", i), lat, 4);
        end
        step();
        check_output("play_done", done, 1);
        check_output("play_busy", busy, 0);
        mode = 2'b00; step();
        check_output("pix_out_hold", pix_out, 8'h17);

        // Record aborted after three words
        mode = 2'b01; step();
        for (int i = 0; i < 3; i++) apply_stimulus(8'(8'h10 + i), i == 0, got, lat);
        mode = 2'b00; step();
        check_output("abort3_rec_len", rec_len, 3);
        check_output("abort3_done", done, 1);

        // Looped playback across two frames, re-arming at each boundary
        mode = 2'b11; step();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                apply_stimulus(8'h00, i == 0, got, lat);
                check_output($sformatf("loop%0d_pix%0d", f, i), got, 32'h10 + i);
            end
            step();
            check_output($sformatf("loop%0d_wrap", f), {busy, done, sram_addr}, {2'b10, 4'd0});
            pix_stb = 1'b1; pix_valid = 1'b1; step();
            pix_stb = 1'b0; pix_valid = 1'b0;
            check_output($sformatf("loop%0d_arm_no_cs", f), sram_cs_n, 1);
        end
        mode = 2'b00; step();
        check_output("loop_exit", {busy, done}, 2'b00);

        // Overflow: extra strobes at A0 and A2 are ignored
        mode = 2'b01; step();
        pix_in = 8'h33; frame_start = 1'b1; pix_stb = 1'b1; pix_valid = 1'b1; step();
        frame_start = 1'b0; step();
        pix_stb = 1'b0;
        check_output("ovf_set", overflow, 1);
        step();
        pix_stb = 1'b1; step();
        pix_stb = 1'b0; pix_valid = 1'b0;
        step(); check_output("ovf_a4_addr", sram_addr, 1);
        step(); check_output("ovf_one_access", {sram_cs_n, sram_addr}, {1'b1, 4'd1});
        mode = 2'b00; step();
        check_output("ovf_rec_len", rec_len, 1);
        check_output("ovf_sticky", overflow, 1);

        // Reset in the middle of a write pulse
        mode = 2'b01; step();
        pix_in = 8'h5A; frame_start = 1'b1; pix_stb = 1'b1; pix_valid = 1'b1; step();
        frame_start = 1'b0; pix_stb = 1'b0; pix_valid = 1'b0; step();
        check_output("mid_a1_we", sram_we_n, 0);
        reset = 1'b0; #1;
        check_output("mid_rst_ctl", {sram_we_n, sram_dq_oe, sram_cs_n, sram_oe_n}, 4'b1011);
        check_output("mid_rst_state", {busy, overflow, done, sram_addr}, 7'd0);
        check_output("mid_rst_rec_len", rec_len, 8);
        mode = 2'b00; step();
        reset = 1'b1; step();

        // Unqualified strobe in RUN starts nothing
        mode = 2'b01; step();
        frame_start = 1'b1; step();
        frame_start = 1'b0;
        pix_stb = 1'b1; pix_valid = 1'b0; step();
        pix_stb = 1'b0;
        check_output("qual_no_cs", sram_cs_n, 1);
        step();
        check_output("qual_idle", {busy, sram_cs_n, sram_addr}, {2'b11, 4'd0});
        mode = 2'b00; step();
        check_output("qual_rec_len0", rec_len, 0);
        check_output("qual_done", done, 1);

        // Empty recording: play once finishes on the first frame_start
        mode = 2'b10; step();
        frame_start = 1'b1; step();
        frame_start = 1'b0;
        check_output("empty_play", {done, busy, sram_cs_n}, 3'b101);
        mode = 2'b00; step();

        check_output("bus_safety", bus_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_frame_recorder.md
Name: sram_frame_recorder

Overview:
- Parametrised SRAM record/playback controller for the HDMI pattern pipeline; successor to the ad-hoc record/playback logic in the top level.
- Runs on clk_x5. Performs one SRAM access per pixel strobe, using a fixed 5-cycle sequence with clean WE/OE/bus-turnaround timing.
- Supports frame-aligned record, single playback and looped playback, plus record-length capture so playback replays exactly what was recorded.
- Sits between the pattern generator (pix_in) and the TMDS symbol mux (pix_out).

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 8, SRAM/pixel data width
FRAME_LEN, 2**ADDR_W, maximum words per recording; must be ≥2 and ≤2**ADDR_W

Ports:
clk_x5  input  1  125 MHz clock; sole clock of the block
reset  input  1  asynchronous, active-low reset
mode  input  2  00 idle/abort, 01 record, 10 play once, 11 play loop
frame_start  input  1  one-cycle pulse at the first active pixel of a frame
pix_stb  input  1  one-cycle pixel strobe, nominally every 5 clk_x5 cycles
pix_valid  input  1  pixel is in active video; qualifies pix_stb
pix_in  input  DATA_W  pixel to record
pix_out  output  DATA_W  played-back pixel
pix_out_valid  output  1  one-cycle pulse when pix_out updates
sram_addr  output  ADDR_W  SRAM address
sram_dq_o  output  DATA_W  write data to the pad tristate
sram_dq_oe  output  1  drive enable for the SRAM data bus
sram_dq_i  input  DATA_W  read data from the pad
sram_we_n  output  1  SRAM write enable, active low
sram_oe_n  output  1  SRAM output enable, active low
sram_cs_n  output  1  SRAM chip select, active low
busy  output  1  state is ARM or RUN
done  output  1  one-cycle pulse when a record or single playback completes
overflow  output  1  sticky; pix_stb arrived while an access was in progress
rec_len  output  ADDR_W+1  word count of the last completed recording

Behaviour:
- Reset (asynchronous, immediate):
  - sram_we_n=1, sram_oe_n=1, sram_cs_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - pix_out=0, pix_out_valid=0, done=0, overflow=0, rec_len=FRAME_LEN, state=IDLE.
  - An access interrupted by reset is abandoned; no partial WE pulse may occur.
- States:
  - IDLE: if mode≠00, latch mode into run_mode → ARM.
  - ARM: if mode==00 → IDLE; on frame_start → RUN, with word counter and sram_addr set to 0.
  - RUN: issue accesses. Leaves on completion or abort (below).
- Access trigger: in RUN, pix_stb && pix_valid && sub-counter idle starts a 5-cycle access (cycles A0..A4).
  - If frame_start and pix_stb coincide on the ARM→RUN edge, that pixel is word 0.
- Write access (record), cycle by cycle:
  - A0: sram_dq_o←pix_in; sram_dq_oe=1; sram_cs_n=0.
  - A1–A2: sram_we_n=0.
  - A3: sram_we_n=1; data still driven.
  - A4: sram_dq_oe=0; sram_cs_n=1; sram_addr increments.
- Read access (play), cycle by cycle:
  - A0: sram_cs_n=0, sram_oe_n=0.
  - A3: pix_out←sram_dq_i; pix_out_valid=1 for one cycle.
  - A4: sram_oe_n=1, sram_cs_n=1; sram_addr increments.
  - Latency: pix_stb → pix_out_valid is 4 cycles.
- Bus safety: sram_dq_oe and sram_oe_n=0 are never asserted in the same cycle. sram_we_n only goes low while sram_dq_oe=1.
- Completion (evaluated at A4 of the last word):
  - Record: limit is FRAME_LEN words. On reaching it, rec_len←FRAME_LEN, pulse done, → IDLE.
  - Play once: limit is rec_len words. On reaching it, pulse done, → IDLE.
  - Play loop: limit is rec_len words. On reaching it, sram_addr←0, → ARM (re-syncs to the next frame_start). No done pulse.
- Abort (mode==00 in RUN):
  - The access in progress finishes through A4, then → IDLE.
  - Aborted record: rec_len←number of words fully written (0 allowed); done pulses.
  - Aborted playback: no done pulse.
- Overflow: pix_stb while the sub-counter is busy sets overflow (sticky until reset). The strobe is ignored. The address does not advance.
- Mode changes other than to 00 are ignored outside IDLE.
- pix_stb without pix_valid, or outside RUN, starts no access.
- pix_out holds its value between updates.
- Playback with rec_len==0 pulses done immediately on the first frame_start (play once); play loop returns to ARM each frame.

Test Plan:
- Write timing: FRAME_LEN=8, mode=01, frame_start+pix_stb with pix_in=0xA5 → dq_oe high A0–A3, we_n low exactly A1–A2, dq_o=0xA5, sram_addr 0→1 at A4.
- Full record then play once: record pixels 0x10..0x17 → done after 8th word, rec_len=8. mode=10 → pix_out 0x10..0x17, each 4 cycles after its strobe; done; oe_n never low while dq_oe=1.
- Abort and loop: abort record after 3 words → rec_len=3. mode=11 over 2 frames → sequence 0x10,0x11,0x12 each frame; sram_addr wraps to 0; state passes through ARM at each frame boundary.
- Overflow: pix_stb at A0 and again at A2 → overflow=1, only one access, sram_addr+1.
- Reset mid-write: assert reset at A1 → we_n=1, dq_oe=0, cs_n=1 immediately; all outputs at reset values; rec_len=FRAME_LEN.
- Qualification: pix_stb with pix_valid=0 in RUN → no cs_n assertion, no address change.
